// File: rtl/matrix_job_sequencer.sv
// Matrix job sequencer: reads packed A/B operands from memory, drives one Alu job,
// writes the signed byte results back, and reports done/status over a cmd handshake.
module matrix_job_sequencer #(
    parameter int unsigned N_ELEM      = 25,
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned SRC_BASE    = 0,
    parameter int unsigned DST_BASE    = 25,
    parameter int unsigned ALU_TIMEOUT = 127
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [7:0]            cmd_scalar,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_we,
    output logic [15:0]           mem_wdata,
    input  logic [15:0]           mem_rdata,
    output logic [2:0]            alu_op,
    output logic [7:0]            alu_scalar,
    output logic [8*N_ELEM-1:0]   alu_a,
    output logic [8*N_ELEM-1:0]   alu_b,
    output logic                  alu_start,
    input  logic                  alu_done,
    input  logic [8*N_ELEM-1:0]   alu_result,
    input  logic                  alu_overflow,
    output logic                  busy,
    output logic                  done,
    output logic                  status_overflow,
    output logic                  status_timeout,
    output logic [2:0]            state_dbg
);

    localparam int unsigned CNT_W  = $clog2(N_ELEM + 1);
    localparam int unsigned WAIT_W = $clog2(ALU_TIMEOUT + 1);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StRead    = 3'd1;
    localparam logic [2:0] StWaitAlu = 3'd2;
    localparam logic [2:0] StWrite   = 3'd3;
    localparam logic [2:0] StDone    = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [CNT_W-1:0]    k_q, k_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [2:0]          op_q;
    logic [7:0]          scalar_q;
    logic [8*N_ELEM-1:0] a_q, b_q, res_q;
    logic                ovf_q, to_q;

    logic       accept, alu_hit, alu_expire, capture;
    logic [7:0] wr_byte;

    assign accept     = cmd_valid && (state_q == StIdle);
    // The start cycle itself never counts as a completion.
    assign alu_hit    = (state_q == StWaitAlu) && (wait_q != '0) && alu_done;
    assign alu_expire = (state_q == StWaitAlu) && !alu_hit &&
                        (wait_q == WAIT_W'(ALU_TIMEOUT));
    assign capture    = (state_q == StRead) && (k_q != '0);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        wait_d  = wait_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StRead;
                    k_d     = '0;
                end
            end
            StRead: begin
                if (k_q == CNT_W'(N_ELEM)) begin
                    state_d = StWaitAlu;
                    k_d     = '0;
                    wait_d  = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            StWaitAlu: begin
                wait_d = wait_q + 1'b1;
                if (alu_hit) begin
                    state_d = StWrite;
                    k_d     = '0;
                end else if (alu_expire) begin
                    state_d = StDone;
                end
            end
            StWrite: begin
                if (k_q == CNT_W'(N_ELEM - 1)) begin
                    state_d = StDone;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            k_q     <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            wait_q  <= wait_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q     <= '0;
            scalar_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            ovf_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            if (accept) begin
                op_q     <= cmd_op;
                scalar_q <= cmd_scalar;
                ovf_q    <= 1'b0;
                to_q     <= 1'b0;
            end
            // Read data lags the address by one cycle, so counter value e+1 holds element e.
            for (int e = 0; e < int'(N_ELEM); e++) begin
                if (capture && (k_q == CNT_W'(e + 1))) begin
                    a_q[8*e +: 8] <= mem_rdata[7:0];
                    b_q[8*e +: 8] <= mem_rdata[15:8];
                end
            end
            if (alu_hit) begin
                res_q <= alu_result;
                ovf_q <= alu_overflow;
            end
            if (alu_expire) begin
                to_q <= 1'b1;
            end
        end
    end

    always_comb begin
        wr_byte = '0;
        for (int e = 0; e < int'(N_ELEM); e++) begin
            if (k_q == CNT_W'(e)) begin
                wr_byte = res_q[8*e +: 8];
            end
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (state_q == StRead) begin
            mem_addr = ADDR_W'(SRC_BASE) + ADDR_W'(k_q);
        end else if (state_q == StWrite) begin
            mem_we    = 1'b1;
            mem_addr  = ADDR_W'(DST_BASE) + ADDR_W'(k_q);
            mem_wdata = {8'h00, wr_byte};
        end
    end

    assign cmd_ready       = (state_q == StIdle);
    assign busy            = (state_q != StIdle);
    assign done            = (state_q == StDone);
    assign alu_start       = (state_q == StWaitAlu) && (wait_q == '0);
    assign alu_op          = op_q;
    assign alu_scalar      = scalar_q;
    assign alu_a           = a_q;
    assign alu_b           = b_q;
    assign status_overflow = ovf_q;
    assign status_timeout  = to_q;
    assign state_dbg       = state_q;

endmodule
